gfsk_packet_demod: RTL

- Sits directly downstream of the symbol-timing recovery stage in the BLE receive chain.
- Consumes the same I/Q sample stream plus the `symbol_clk` strobe.
- FM-discriminates and integrates each symbol, slices bits, then correlates against the access address.
- Once the address is found, deserialises the header, payload and CRC into bytes for the link-layer/CRC checker.

---
 rtl/gfsk_packet_demod.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/gfsk_packet_demod.sv
// BLE GFSK packet demodulator: FM discriminator, symbol slicer, access-address correlator, byte deserialiser.
// Define DEWHITEN_EN to de-whiten header/payload/CRC with the channel-seeded x^7+x^4+1 sequence.
module gfsk_packet_demod #(
    parameter int unsigned DATA_WIDTH     = 4,
    parameter int unsigned ACC_WIDTH      = 14,
    parameter logic [31:0] ACCESS_ADDRESS = 32'h8E89BED6,
    parameter int unsigned AA_MAX_ERR     = 1,
    parameter int unsigned MAX_LEN        = 255
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    input  logic signed [DATA_WIDTH-1:0] q_data,
    input  logic                         symbol_clk,
    input  logic [5:0]                   channel,
    output logic                         aa_detected,
    output logic [7:0]                   byte_data,
    output logic                         byte_valid,
    output logic                         pkt_start,
    output logic                         pkt_end,
    output logic                         busy
);

    localparam int unsigned DISC_W = 2 * DATA_WIDTH + 1;
    localparam int unsigned SUM_W  = ((ACC_WIDTH > DISC_W) ? ACC_WIDTH : DISC_W) + 1;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned REM_W  = 9;
    localparam logic signed [ACC_WIDTH-1:0] ACC_HI = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_LO = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_W-1:0]     SUM_HI = SUM_W'(ACC_HI);
    localparam logic signed [SUM_W-1:0]     SUM_LO = SUM_W'(ACC_LO);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  i_prev, q_prev;
    logic signed [ACC_WIDTH-1:0]   acc, acc_sat;
    logic signed [DISC_W-1:0]      disc;
    logic signed [SUM_W-1:0]       sum;
    logic                          sym_evt, raw_bit, data_bit;
    logic [31:0]                   aa_sr, aa_next;
    logic [CNT_W-1:0]              aa_cnt, aa_cnt_next;
    logic                          aa_hit;
    logic [7:0]                    byte_sr, byte_next;
    logic [2:0]                    bit_cnt;
    logic                          byte_done, hdr_idx, last_byte;
    logic [REM_W-1:0]              remaining, len_clamp;
    logic                          aa_det_d, byte_valid_d, pkt_start_d, pkt_end_d;

    assign sym_evt = en & symbol_clk;

    // Cross-product discriminator, running sum and slicer (sum of exactly 0 slices to 0)
    always_comb begin
        disc = DISC_W'(i_prev) * DISC_W'(q_data) - DISC_W'(q_prev) * DISC_W'(i_data);
        sum  = SUM_W'(acc) + SUM_W'(disc);
        if (sum > SUM_HI)      acc_sat = ACC_HI;
        else if (sum < SUM_LO) acc_sat = ACC_LO;
        else                   acc_sat = ACC_WIDTH'(sum);
        raw_bit = ~sum[SUM_W-1] & (|sum);
    end

    // Correlator window and byte assembly, both LSB-first
    always_comb begin
        aa_next     = {raw_bit, aa_sr[31:1]};
        aa_cnt_next = (aa_cnt == CNT_W'(32)) ? aa_cnt : aa_cnt + CNT_W'(1);
        aa_hit      = (aa_cnt_next == CNT_W'(32)) &&
                      (32'($countones(aa_next ^ ACCESS_ADDRESS)) <= AA_MAX_ERR);
        byte_next   = {data_bit, byte_sr[7:1]};
        byte_done   = (bit_cnt == 3'd7);
        last_byte   = (remaining == REM_W'(1));
        len_clamp   = (REM_W'(byte_next) > REM_W'(MAX_LEN)) ? REM_W'(MAX_LEN) : REM_W'(byte_next);
    end

`ifdef DEWHITEN_EN
    logic [6:0] whit_q;

    assign data_bit = raw_bit ^ whit_q[6];

    // Seeded from the channel on address match, stepped once per packet bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            whit_q <= '0;
        end else if (sym_evt) begin
            if (state_q == S_SEARCH) begin
                if (aa_hit) whit_q <= {channel[0], channel[1], channel[2], channel[3],
                                       channel[4], channel[5], 1'b1};
            end else begin
                whit_q <= {whit_q[5], whit_q[4], whit_q[3] ^ whit_q[6], whit_q[2],
                           whit_q[1], whit_q[0], whit_q[6]};
            end
        end
    end
`else
    logic unused_channel;

    assign unused_channel = ^channel;
    assign data_bit       = raw_bit;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_SEARCH;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (sym_evt) begin
            case (state_q)
                S_SEARCH:  if (aa_hit)                 state_d = S_HEADER;
                S_HEADER:  if (byte_done && hdr_idx)   state_d = S_PAYLOAD;
                S_PAYLOAD: if (byte_done && last_byte) state_d = S_SEARCH;
                default:                               state_d = S_SEARCH;
            endcase
        end
    end

    always_comb begin
        aa_det_d     = 1'b0;
        byte_valid_d = 1'b0;
        pkt_start_d  = 1'b0;
        pkt_end_d    = 1'b0;
        if (sym_evt) begin
            case (state_q)
                S_SEARCH:  aa_det_d = aa_hit;
                S_HEADER: begin
                    byte_valid_d = byte_done;
                    pkt_start_d  = byte_done & ~hdr_idx;
                end
                S_PAYLOAD: begin
                    byte_valid_d = byte_done;
                    pkt_end_d    = byte_done & last_byte;
                end
                default: ;
            endcase
        end
    end

    // Datapath state; everything here advances only on en
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_prev    <= '0;
            q_prev    <= '0;
            acc       <= '0;
            aa_sr     <= '0;
            aa_cnt    <= '0;
            byte_sr   <= '0;
            bit_cnt   <= '0;
            hdr_idx   <= 1'b0;
            remaining <= '0;
        end else if (en) begin
            i_prev <= i_data;
            q_prev <= q_data;
            acc    <= symbol_clk ? '0 : acc_sat;
            if (symbol_clk) begin
                case (state_q)
                    S_SEARCH: begin
                        aa_sr  <= aa_next;
                        aa_cnt <= aa_cnt_next;
                        if (aa_hit) begin
                            bit_cnt <= '0;
                            hdr_idx <= 1'b0;
                        end
                    end
                    S_HEADER: begin
                        byte_sr <= byte_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            hdr_idx <= 1'b1;
                            if (hdr_idx) remaining <= len_clamp + REM_W'(3);
                        end
                    end
                    S_PAYLOAD: begin
                        byte_sr <= byte_next;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_done) begin
                            remaining <= remaining - REM_W'(1);
                            if (last_byte) begin
                                aa_sr  <= '0;
                                aa_cnt <= '0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output pulses are rewritten every clk so they stay one clk wide regardless of en
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aa_detected <= 1'b0;
            byte_valid  <= 1'b0;
            pkt_start   <= 1'b0;
            pkt_end     <= 1'b0;
            busy        <= 1'b0;
            byte_data   <= '0;
        end else begin
            aa_detected <= aa_det_d;
            byte_valid  <= byte_valid_d;
            pkt_start   <= pkt_start_d;
            pkt_end     <= pkt_end_d;
            busy        <= (state_d != S_SEARCH);
            if (byte_valid_d) byte_data <= byte_next;
        end
    end

endmodule
